// File: rtl/sp_ram_burst_reader.sv
// Burst read engine: turns a (base, length) job into credit-limited SRAM word reads
// and replays the returned words as a valid/ready stream with a last-beat tag.
module sp_ram_burst_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              ram_cs,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_req,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  remaining;
  logic              cs_q;
  logic              last_q;
  logic              pend;
  logic              pend_last;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit;
  logic              has_credit;

  // Credit counts buffered words plus the read on the bus and the read whose data is returning.
  assign credit     = {1'b0, count} + {{CNT_W{1'b0}}, cs_q} + {{CNT_W{1'b0}}, pend};
  assign has_credit = credit < DEPTH_C;

  assign push      = pend;
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last  = out_valid ? mem_last[rd_ptr] : 1'b0;

  assign ram_cs     = cs_q;
  assign ram_oe     = cs_q;
  assign ram_w_req  = 1'b0;
  assign ram_w_data = '0;
  assign fsm_state  = state;

  // remaining counts words not yet scheduled; the first word is scheduled on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cs_q      <= 1'b0;
      last_q    <= 1'b0;
      ram_addr  <= '0;
      next_addr <= '0;
      remaining <= '0;
    end else begin
      cs_q   <= 1'b0;
      last_q <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cs_q      <= 1'b1;
              last_q    <= req_len == LEN_W'(1);
              ram_addr  <= req_base_addr;
              next_addr <= req_base_addr + ADDR_W'(1);
              remaining <= req_len - LEN_W'(1);
              state     <= (req_len == LEN_W'(1)) ? DRAIN : READ;
            end
          end
        end
        READ: begin
          if (remaining != '0 && has_credit) begin
            cs_q      <= 1'b1;
            last_q    <= remaining == LEN_W'(1);
            ram_addr  <= next_addr;
            next_addr <= next_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_last <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      pend      <= cs_q;
      pend_last <= cs_q && last_q;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: out_data/out_last are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= ram_r_data;
      mem_last[wr_ptr] <= pend_last;
    end
  end

endmodule
